// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST JTAG data register: FSM states,
// strobe priority encoding and an even-parity helper.
package bist_pkg;

  localparam int BIST_MAX_WIDTH = 64;

  typedef enum logic {
    BIST_DR_IDLE  = 1'b0,
    BIST_DR_SHIFT = 1'b1
  } bist_dr_state_e;

  typedef enum logic [1:0] {
    BIST_STB_NONE    = 2'd0,
    BIST_STB_CAPTURE = 2'd1,
    BIST_STB_SHIFT   = 2'd2,
    BIST_STB_UPDATE  = 2'd3
  } bist_strobe_e;

  // Only the highest-priority strobe acts; nothing acts while deselected.
  function automatic bist_strobe_e bist_strobe_sel(input logic sel, input logic cap,
                                                   input logic shift, input logic upd);
    if (!sel)       return BIST_STB_NONE;
    else if (cap)   return BIST_STB_CAPTURE;
    else if (shift) return BIST_STB_SHIFT;
    else if (upd)   return BIST_STB_UPDATE;
    else            return BIST_STB_NONE;
  endfunction

  function automatic logic bist_even_parity(input logic [BIST_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bist_bit_counter.sv
// Saturating shift-bit counter with synchronous clear; done flags a full-length shift.
module bist_bit_counter #(
  parameter int MAX_COUNT = 16,
  parameter int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic inc,
  output logic done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(MAX_COUNT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CW'(MAX_COUNT));

endmodule

// File: rtl/bist_data_reg.sv
// JTAG test data register for the BIST path with bit counting and length checking.
// Optional even parity bit is built when BIST_DATA_REG_PARITY_EN is defined.
//
//   state         | meaning
//   BIST_DR_IDLE  | no capture pending; shifts act as a bypass chain, updates ignored
//   BIST_DR_SHIFT | captured; shifts are counted, next update is checked and applied
module bist_data_reg
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter bit               LSB_FIRST    = 1'b1,
  parameter logic [WIDTH-1:0] UPDATE_RESET = '0
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             SELECT,
  input  logic             CAPTURE_DR,
  input  logic             SHIFT_DR,
  input  logic             UPDATE_DR,
  input  logic             TDI,
  input  logic [WIDTH-1:0] CAPTURE_DATA,
  output logic             TDO,
  output logic [WIDTH-1:0] UPDATE_DATA,
  output logic             UPDATE_VALID,
  output logic             LEN_ERR,
  output logic             PARITY_ERR
);

`ifdef BIST_DATA_REG_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif

  bist_strobe_e   stb;
  bist_dr_state_e state_q, state_d;
  logic [LEN-1:0]   sr, cap_word;
  logic [WIDTH-1:0] sr_data;
  logic par_good, cnt_done;
  logic sr_load, sr_shift, cnt_inc, upd_load, len_set;

  assign stb = bist_strobe_sel(SELECT, CAPTURE_DR, SHIFT_DR, UPDATE_DR);

`ifdef BIST_DATA_REG_PARITY_EN
  logic cap_par, par_set;
  // Parity sits at the last-out end so it follows the data on TDO and is the last bit shifted in.
  assign cap_par  = bist_even_parity(BIST_MAX_WIDTH'(CAPTURE_DATA));
  assign cap_word = LSB_FIRST ? {cap_par, CAPTURE_DATA} : {CAPTURE_DATA, cap_par};
  assign sr_data  = LSB_FIRST ? sr[WIDTH-1:0] : sr[LEN-1:1];
  assign par_good = (LSB_FIRST ? sr[LEN-1] : sr[0]) == bist_even_parity(BIST_MAX_WIDTH'(sr_data));
`else
  assign cap_word = CAPTURE_DATA;
  assign sr_data  = sr;
  assign par_good = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    cnt_inc  = 1'b0;
    upd_load = 1'b0;
    len_set  = 1'b0;
`ifdef BIST_DATA_REG_PARITY_EN
    par_set  = 1'b0;
`endif
    unique case (stb)
      BIST_STB_CAPTURE: begin
        sr_load = 1'b1;
        state_d = BIST_DR_SHIFT;
      end
      BIST_STB_SHIFT: begin
        sr_shift = 1'b1;
        cnt_inc  = (state_q == BIST_DR_SHIFT);
      end
      BIST_STB_UPDATE: begin
        if (state_q == BIST_DR_SHIFT) begin
          state_d = BIST_DR_IDLE;
          if (!cnt_done) begin
            len_set = 1'b1;
          end else if (par_good) begin
            upd_load = 1'b1;
          end else begin
`ifdef BIST_DATA_REG_PARITY_EN
            par_set = 1'b1;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  bist_bit_counter #(.MAX_COUNT(LEN)) u_bit_counter (
    .clk   (TCK),
    .rst_b (TRST),
    .clr   (sr_load),
    .inc   (cnt_inc),
    .done  (cnt_done)
  );

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      state_q      <= BIST_DR_IDLE;
      sr           <= '0;
      UPDATE_DATA  <= UPDATE_RESET;
      UPDATE_VALID <= 1'b0;
      LEN_ERR      <= 1'b0;
    end else begin
      state_q      <= state_d;
      UPDATE_VALID <= upd_load;
      if (sr_load) begin
        sr <= cap_word;
      end else if (sr_shift) begin
        sr <= LSB_FIRST ? {TDI, sr[LEN-1:1]} : {sr[LEN-2:0], TDI};
      end
      if (upd_load) UPDATE_DATA <= sr_data;
      if (sr_load)      LEN_ERR <= 1'b0;
      else if (len_set) LEN_ERR <= 1'b1;
    end
  end

`ifdef BIST_DATA_REG_PARITY_EN
  always_ff @(posedge TCK) begin
    if (!TRST)        PARITY_ERR <= 1'b0;
    else if (sr_load) PARITY_ERR <= 1'b0;
    else if (par_set) PARITY_ERR <= 1'b1;
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign TDO = SELECT & (LSB_FIRST ? sr[0] : sr[LEN-1]);

endmodule

// File: tb/tb_bist_data_reg.sv
// Scoreboard bench for bist_data_reg: LSB-first and MSB-first instances share stimulus.
module tb_bist_data_reg;

`ifdef BIST_DATA_REG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic TCK = 1'b0, TRST = 1'b0, SELECT = 1'b0;
  logic CAPTURE_DR = 1'b0, SHIFT_DR = 1'b0, UPDATE_DR = 1'b0, TDI = 1'b0;
  logic [15:0] CAPTURE_DATA = '0;

  logic tdo_l, uv_l, le_l, pe_l, tdo_m, uv_m, le_m, pe_m;
  logic [15:0] ud_l, ud_m;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_l = 1'b0, mon_m = 1'b0;
  logic q_l[$];
  logic q_m[$];
  logic [15:0] q_u[$];

  bist_data_reg #(.WIDTH(16), .LSB_FIRST(1'b1), .UPDATE_RESET(16'h0000)) u_lsb (
    .TCK(TCK), .TRST(TRST), .SELECT(SELECT), .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR),
    .UPDATE_DR(UPDATE_DR), .TDI(TDI), .CAPTURE_DATA(CAPTURE_DATA), .TDO(tdo_l),
    .UPDATE_DATA(ud_l), .UPDATE_VALID(uv_l), .LEN_ERR(le_l), .PARITY_ERR(pe_l));

  bist_data_reg #(.WIDTH(16), .LSB_FIRST(1'b0), .UPDATE_RESET(16'h0000)) u_msb (
    .TCK(TCK), .TRST(TRST), .SELECT(SELECT), .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR),
    .UPDATE_DR(UPDATE_DR), .TDI(TDI), .CAPTURE_DATA(CAPTURE_DATA), .TDO(tdo_m),
    .UPDATE_DATA(ud_m), .UPDATE_VALID(uv_m), .LEN_ERR(le_m), .PARITY_ERR(pe_m));

  always #5 TCK = ~TCK;

  task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic s, input logic u, input logic d);
    CAPTURE_DR = c; SHIFT_DR = s; UPDATE_DR = u; TDI = d;
    @(posedge TCK); #1;
    CAPTURE_DR = 1'b0; SHIFT_DR = 1'b0; UPDATE_DR = 1'b0; TDI = 1'b0;
  endtask

  task automatic capture(input logic [15:0] d);
    CAPTURE_DATA = d;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Shifts din LSB-first; expected TDO comes from the captured word (plus parity when built in).
  task automatic shift_seq(input logic [15:0] din, input logic [15:0] cap, input int n,
                           input logic par_in);
    for (int i = 0; i < n; i++) begin
      if (mon_l) q_l.push_back(cap[i]);
      if (mon_m) q_m.push_back(cap[15-i]);
      cyc(1'b0, 1'b1, 1'b0, din[i]);
    end
    if (PAR && n == 16) begin
      if (mon_l) q_l.push_back(^cap);
      if (mon_m) q_m.push_back(^cap);
      cyc(1'b0, 1'b1, 1'b0, par_in);
    end
  endtask

  task automatic update(input logic ok, input logic [15:0] d);
    if (ok) q_u.push_back(d);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge TCK) begin
    logic eb;
    logic [15:0] ew;
    if (TRST && SELECT && SHIFT_DR && !CAPTURE_DR) begin
      if (mon_l) begin
        if (q_l.size() == 0) check1("tdo_lsb_unexpected", 32'd1, 32'd0);
        else begin eb = q_l.pop_front(); check1("tdo_lsb", 32'(tdo_l), 32'(eb)); end
      end
      if (mon_m) begin
        if (q_m.size() == 0) check1("tdo_msb_unexpected", 32'd1, 32'd0);
        else begin eb = q_m.pop_front(); check1("tdo_msb", 32'(tdo_m), 32'(eb)); end
      end
    end
    if (uv_l) begin
      if (q_u.size() == 0) check1("update_valid_unexpected", 32'd1, 32'd0);
      else begin ew = q_u.pop_front(); check1("update_data", 32'(ud_l), 32'(ew)); end
    end
  end

  initial begin
    SELECT = 1'b1;
    TRST   = 1'b0;
    repeat (2) @(posedge TCK);
    #1;
    check1("rst_tdo", 32'(tdo_l), 32'd0);
    check1("rst_update_data", 32'(ud_l), 32'h0);
    check1("rst_update_valid", 32'(uv_l), 32'd0);
    check1("rst_flags", {30'd0, le_l, pe_l}, 32'd0);
    TRST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // LSB-first capture/shift/update
    mon_l = 1'b1;
    capture(16'hA5C3);
    shift_seq(16'h1234, 16'hA5C3, 16, ^16'h1234);
    update(1'b1, 16'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check1("good_flags", {30'd0, le_l, pe_l}, 32'd0);

    // MSB-first
    mon_l = 1'b0; mon_m = 1'b1;
    capture(16'h8001);
    shift_seq(16'hBEEF, 16'h8001, 16, ^16'hBEEF);
    update(1'b1, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check1("msb_update_data", 32'(ud_m), 32'hF77D);
    mon_m = 1'b0; mon_l = 1'b1;

    // Length error
    capture(16'h0F0F);
    shift_seq(16'h0000, 16'h0F0F, 15, 1'b0);
    update(1'b0, 16'h0000);
    check1("len_err_set", 32'(le_l), 32'd1);
    check1("len_err_data_hold", 32'(ud_l), 32'hBEEF);
    capture(16'hFFFF);
    check1("len_err_cleared", 32'(le_l), 32'd0);

    // Deselected: TDO gated, strobes ignored
    SELECT = 1'b0;
    #1;
    check1("tdo_gated", 32'(tdo_l), 32'd0);
    capture(16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    SELECT = 1'b1;
    #1;
    check1("deselect_no_capture", 32'(tdo_l), 32'd1);
    check1("deselect_no_update", 32'(le_l), 32'd0);

    // Priority: capture wins over update in SHIFT
    capture(16'h1111);
    shift_seq(16'h5555, 16'h1111, 16, ^16'h5555);
    CAPTURE_DATA = 16'h0002;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check1("prio_capture_tdo", 32'(tdo_l), 32'd0);
    check1("prio_data_hold", 32'(ud_l), 32'hBEEF);
    update(1'b0, 16'h0000);
    check1("prio_cnt_cleared", 32'(le_l), 32'd1);
    capture(16'h00F0);
    shift_seq(16'h00F0, 16'h00F0, 16, ^16'h00F0);
    update(1'b1, 16'h00F0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    update(1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check1("idle_update_data", 32'(ud_l), 32'h00F0);
    check1("idle_update_flags", {30'd0, le_l, pe_l}, 32'd0);

`ifdef BIST_DATA_REG_PARITY_EN
    capture(16'h0007);
    shift_seq(16'h0003, 16'h0007, 16, 1'b1);
    update(1'b0, 16'h0000);
    check1("parity_err_set", 32'(pe_l), 32'd1);
    check1("parity_err_data_hold", 32'(ud_l), 32'h00F0);
    capture(16'h0007);
    check1("parity_err_cleared", 32'(pe_l), 32'd0);
    shift_seq(16'h0003, 16'h0007, 16, 1'b0);
    update(1'b1, 16'h0003);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check1("parity_good_flags", {30'd0, le_l, pe_l}, 32'd0);
`else
    check1("parity_tied_low", {30'd0, pe_l, pe_m}, 32'd0);
`endif

    // Reset mid-shift
    capture(16'hA5C3);
    shift_seq(16'hFFFF, 16'hA5C3, 8, 1'b0);
    check1("pre_reset_tdo", 32'(tdo_l), 32'd1);
    TRST = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check1("mid_rst_tdo", 32'(tdo_l), 32'd0);
    check1("mid_rst_update_data", 32'(ud_l), 32'h0);
    check1("mid_rst_outputs", {29'd0, uv_l, le_l, pe_l}, 32'd0);
    TRST = 1'b1;
    update(1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check1("post_rst_idle_update", 32'(ud_l), 32'h0);

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check1("tdo_lsb_queue_drained", 32'(q_l.size()), 32'd0);
    check1("tdo_msb_queue_drained", 32'(q_m.size()), 32'd0);
    check1("update_queue_drained", 32'(q_u.size()), 32'd0);
    check1("msb_idle_outputs", {30'd0, uv_m, le_m}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
